// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD request scheduler.
//   - default parameter values (operand width, requester count, WAIT timeout)
//   - timeout counter width and requester index width
//   - scheduler FSM state encoding
package gcd_pkg;

    localparam int WIDTH_D   = 8;
    localparam int N_REQ_D   = 4;
    localparam int TIMEOUT_D = 1023;
    localparam int CNT_W     = 10;   // holds TIMEOUT_D
    localparam int IDX_W     = 2;    // requester index width for N_REQ_D

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_CAPTURE,
        S_RELEASE,
        S_BYPASS
    } state_t;

endpackage

// File: rtl/gcd_sched_if.sv
// gcd_sched_if: requester-side and core-side signals of the GCD scheduler.
//   Requester side : req, x_in, y_in (to scheduler); ack, result, res_id, err (back)
//   Core side      : core_go, core_x, core_y, core_clr (to core); core_done, core_gcd (back)
// Modports:
//   slave  - the scheduler itself
//   master - environment: requesters plus the shared GCD core
interface gcd_sched_if import gcd_pkg::*; #(
    parameter int WIDTH = WIDTH_D,
    parameter int N_REQ = N_REQ_D
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] x_in;
    logic [N_REQ*WIDTH-1:0] y_in;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       result;
    logic [IDX_W-1:0]       res_id;
    logic                   err;
    logic                   core_go;
    logic [WIDTH-1:0]       core_x;
    logic [WIDTH-1:0]       core_y;
    logic                   core_clr;
    logic                   core_done;
    logic [WIDTH-1:0]       core_gcd;

    modport slave (
        input  req, x_in, y_in, core_done, core_gcd,
        output ack, result, res_id, err, core_go, core_x, core_y, core_clr
    );

    modport master (
        output req, x_in, y_in, core_done, core_gcd,
        input  ack, result, res_id, err, core_go, core_x, core_y, core_clr
    );
endinterface

// File: rtl/gcd_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - request levels, ptr - index searched first
//   win - first set request at or after ptr (ascending, wrapping)
//   any - at least one request is set
module rr_pick import gcd_pkg::*; #(
    parameter int N_REQ = N_REQ_D
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             any
);
    always_comb begin
        win = '0;
        any = |req;
        // Walk from the farthest offset down to ptr so the closest set bit
        // is the last assignment and therefore wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ])
                win = IDX_W'((int'(ptr) + k) % N_REQ);
        end
    end
endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: arbitrates N_REQ requesters onto one shared GCD core.
//   clk  - system clock, rising edge
//   clr  - asynchronous active-high reset (also forwarded to core_clr)
//   bus  - gcd_sched_if.slave: requester handshake and core control
// A winner is chosen round-robin in IDLE and its operands latched. Zero
// operands are answered locally (BYPASS); otherwise the core is started,
// watched for core_done with a timeout, its result returned, and the core
// restarted via core_clr before the next grant.
module gcd_sched import gcd_pkg::*; #(
    parameter int WIDTH   = WIDTH_D,
    parameter int N_REQ   = N_REQ_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic        clk,
    input  logic        clr,
    gcd_sched_if.slave  bus
);
    state_t             state, nxt;
    logic [IDX_W-1:0]   ptr, win, pick;
    logic               any;
    logic [CNT_W-1:0]   cnt;
    logic               abort;
    logic [WIDTH-1:0]   opx, opy, res;
    logic [WIDTH-1:0]   sel_x, sel_y;
    logic               zero_op, timeout;
    logic [N_REQ-1:0]   ack;
    logic               err, go, rel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick),
        .any (any)
    );

    assign sel_x   = bus.x_in[int'(pick)*WIDTH +: WIDTH];
    assign sel_y   = bus.y_in[int'(pick)*WIDTH +: WIDTH];
    assign zero_op = (sel_x == '0) || (sel_y == '0);
    // cnt counts completed WAIT cycles; this is the last allowed one.
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next state
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (any) nxt = zero_op ? S_BYPASS : S_GRANT;
            S_GRANT:   nxt = S_WAIT;
            S_WAIT:    if (bus.core_done || timeout) nxt = S_CAPTURE;
            S_CAPTURE: nxt = S_RELEASE;
            S_RELEASE: nxt = S_IDLE;
            S_BYPASS:  nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ack = '0;
        err = 1'b0;
        go  = 1'b0;
        rel = 1'b0;
        case (state)
            S_GRANT:   go = 1'b1;
            S_CAPTURE: begin
                ack[win] = 1'b1;
                err      = abort;
            end
            S_RELEASE: rel = 1'b1;
            S_BYPASS:  begin
                ack[win] = 1'b1;
                err      = (opx == '0) && (opy == '0);
            end
            default: ;
        endcase
    end

    // Datapath: winner/operand latch, timeout counter, result register.
    // result is loaded on the edge entering CAPTURE/BYPASS so it is valid
    // in the same cycle as ack.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            abort <= 1'b0;
            opx   <= '0;
            opy   <= '0;
            res   <= '0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    win <= pick;
                    ptr <= IDX_W'((int'(pick) + 1) % N_REQ);
                    opx <= sel_x;
                    opy <= sel_y;
                    if (zero_op) res <= sel_x | sel_y;   // gcd(0,v) = v
                end
                S_GRANT: begin
                    cnt   <= '0;
                    abort <= 1'b0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.core_done) begin
                        res <= bus.core_gcd;
                    end else if (timeout) begin
                        res   <= '0;
                        abort <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack      = ack;
    assign bus.err      = err;
    assign bus.result   = res;
    assign bus.res_id   = win;
    assign bus.core_go  = go;
    assign bus.core_x   = opx;
    assign bus.core_y   = opy;
    assign bus.core_clr = clr | rel;

endmodule
